// File: rtl/jtframe_cheat_dump.sv
// Streams the 18-bit cheat memory out as loader-compatible bytes, four words per 9-byte group,
// optionally scrambled so the loader's descrambler restores the original bytes.
module jtframe_cheat_dump #(
  parameter int          AW       = 10,
  parameter bit          SCR_EN   = 1'b0,
  parameter logic [15:0] SCRAMBLE = 16'h0000
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   nwords,
  output logic [AW-1:0] mem_addr,
  input  logic [17:0]   mem_data,
  output logic [7:0]    dump_data,
  output logic [7:0]    dump_addr,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, DONE} state_t;

  state_t        state;
  logic [24:0]   sbuf;
  logic [4:0]    fill;
  logic [AW+1:0] wcnt, wlast, nw_up;
  logic [AW:0]   nw;
  logic [17:0]   word;
  logic [24:0]   wbuf;

  // Inverse of the loader descrambler: pair swaps on the high mask nibble, XOR, then the low nibble.
  function automatic logic [7:0] scr(input logic [7:0] b, input logic [7:0] a);
    logic [7:0] m, r;
    m = a ^ SCRAMBLE[7:0];
    r = b;
    for (int i = 0; i < 4; i++)
      if (m[4+i]) r[2*i +: 2] = {r[2*i], r[2*i+1]};
    r = r ^ SCRAMBLE[15:8];
    for (int i = 0; i < 4; i++)
      if (m[i]) r[2*i +: 2] = {r[2*i], r[2*i+1]};
    return SCR_EN ? r : b;
  endfunction

  // Words past nwords are padding: zero, and the memory is never addressed for them.
  always_comb begin
    nw_up = {1'b0, nwords} + (AW+2)'(3);
    word  = (wcnt < {1'b0, nw}) ? mem_data : 18'd0;
    wbuf  = sbuf | ({7'd0, word} << fill);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sbuf       <= '0;
      fill       <= '0;
      wcnt       <= '0;
      wlast      <= '0;
      nw         <= '0;
      mem_addr   <= '0;
      dump_data  <= '0;
      dump_addr  <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (nwords == '0) done <= 1'b1;
          else begin
            nw        <= nwords;
            wlast     <= nw_up & ~(AW+2)'(3);
            wcnt      <= '0;
            sbuf      <= '0;
            fill      <= '0;
            dump_addr <= '0;
            mem_addr  <= '0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          sbuf       <= wbuf;
          fill       <= fill + 5'd18;
          wcnt       <= wcnt + (AW+2)'(1);
          dump_data  <= scr(wbuf[7:0], dump_addr);
          dump_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: if (dump_valid && dump_ready) begin
          sbuf      <= {8'd0, sbuf[24:8]};
          fill      <= fill - 5'd8;
          dump_addr <= dump_addr + 8'd1;
          if (fill >= 5'd16) dump_data <= scr(sbuf[15:8], dump_addr + 8'd1);
          else begin
            // Buffer drained below a byte: fetch the next word or finish the group.
            dump_valid <= 1'b0;
            if (wcnt < wlast) begin
              state <= FETCH;
              if (wcnt < {1'b0, nw}) mem_addr <= wcnt[AW-1:0];
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
